mtm_alu_frame_decoder: RTL and testbench
========================================

Name: mtm_alu_frame_decoder

Overview:
- Sits directly downstream of the serial deserializer. Consumes its 10-bit packets and assembles one ALU request frame: 4 B bytes, then 4 A bytes, then 1 CMD byte.
- Checks the frame's CRC, opcode and packet count, then hands either a validated operand set or an error code to the ALU core.

Parameters:
- DATA_PKTS, 8, number of data packets per frame (4 B bytes followed by 4 A bytes, MSB byte first).
- CRC_INIT, 4'h0, initial CRC register value at frame start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- packet  input  10  packet from the deserializer. [9] is the type (0 = DATA, 1 = CMD); [8:1] is the payload byte, MSB first; [0] is ignored.
- data_valid  input  1  one-cycle strobe; packet is valid while it is high.
- a_out  output  32  operand A.
- b_out  output  32  operand B.
- op_out  output  3  opcode.
- frame_valid  output  1  one-cycle pulse: a_out, b_out and op_out are valid.
- err_flags  output  3  {ERR_DATA, ERR_CRC, ERR_OP}; one-hot when err_valid is high.
- err_valid  output  1  one-cycle pulse: the frame was rejected.

Behaviour:
- Reset (asynchronous, rst low): all outputs 0, state COLLECT, pkt_cnt 0, crc = CRC_INIT, shift registers 0.
- Only cycles with data_valid = 1 are processed; other cycles hold all state.
- CMD payload format: {1'b0, OP[2:0], CRC[3:0]}.
- CRC definition:
  - Polynomial x^4+x+1.
  - Message = B[31:0], A[31:0], 1'b1, OP[2:0] (68 bits, MSB first); zero-augmented remainder.
  - Updated per byte: each DATA byte is folded into crc on acceptance.
  - At CMD, the nibble {1, OP} is folded in combinationally and compared with the received CRC.
- States:
  - COLLECT
    - DATA packet: shift byte into the 64-bit {B,A} register, crc updated, pkt_cnt++.
    - Once pkt_cnt reaches DATA_PKTS+1 it saturates and a sticky overflow flag is set; further bytes are still shifted but the frame is already doomed.
    - CMD packet: evaluate the frame in the same cycle and go to REPORT.
  - REPORT (exactly one cycle), outputs registered on entry:
    - Error priority is ERR_DATA > ERR_CRC > ERR_OP; only the highest-priority error is flagged.
    - ERR_DATA: pkt_cnt != DATA_PKTS.
    - ERR_CRC: CRC mismatch.
    - ERR_OP: OP not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
    - No error: frame_valid = 1 with a_out, b_out and op_out loaded.
    - Any error: err_valid = 1 with err_flags set; a_out, b_out and op_out hold their previous values.
    - Leaving REPORT clears pkt_cnt, crc and the overflow flag, then returns to COLLECT.
- Latency: frame_valid or err_valid rises on the clock edge after the cycle where the CMD packet is sampled.
- Pulses deassert after one cycle; a_out, b_out and op_out hold until the next good frame.
- A data_valid arriving during REPORT is processed as the first packet of the next frame; no packet is dropped. This requires the per-frame state to be cleared and the new packet loaded in the same edge.
- A CMD arriving with pkt_cnt = 0 produces ERR_DATA.
- rst low mid-frame: the frame is discarded and no pulse is emitted.

Decomposition:
- Shared package mtm_alu_pkg:
  - Opcode constants OP_AND/OP_OR/OP_ADD/OP_SUB.
  - Packet type constants PKT_DATA/PKT_CMD.
  - err_flags bit indices.
  - CRC4 polynomial constant.
- Sub-module mtm_alu_crc4_step: combinational, 4-bit crc in plus N-bit data in (N = 8 or 4) gives the next crc. Instanced twice: once for the byte update, once for the CMD nibble.

Test Plan:
- Good frame: 8 DATA packets with payload 8'h00, then CMD payload 8'h0B (OP = 000, CRC = 1011) -> frame_valid pulse 1 cycle after CMD; a_out = 0, b_out = 0, op_out = 000; err_valid = 0.
- CRC error: same data, CMD payload 8'h0A -> err_valid = 1, err_flags = 3'b010, frame_valid = 0.
- Bad opcode: same data, CMD payload 8'h2D (OP = 010, CRC = 1101 valid) -> err_flags = 3'b001.
- Count error:
  - 7 DATA packets then CMD 8'h0B -> err_flags = 3'b100.
  - 10 DATA packets then CMD -> err_flags = 3'b100, even when the CRC also mismatches.
- Back-to-back frames:
  - The first DATA packet of frame 2 arrives in the REPORT cycle of frame 1 -> both frames reported correctly.
  - Frame 2 with B = 32'h01020304, A = 32'h05060708, OP = ADD and the model-computed CRC -> a_out = 32'h05060708, b_out = 32'h01020304.
- Reset mid-frame: rst low after 5 DATA packets, then a full good frame -> no pulse during or after the reset; exactly one frame_valid, for the second frame.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU frame decoder slice.
// Holds the opcode and packet-type encodings, the bit positions inside
// err_flags, the CRC4 generator polynomial and the FSM state type.
package mtm_alu_pkg;

  // ALU opcodes accepted by the core; every other 3-bit value is rejected.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Packet type carried in bit 9 of every deserializer packet.
  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  // err_flags is {ERR_DATA, ERR_CRC, ERR_OP}.
  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // x^4 + x + 1 with the implicit x^4 term dropped.
  localparam logic [3:0] CRC4_POLY = 4'h3;

  typedef enum logic {
    ST_COLLECT,
    ST_REPORT
  } state_e;

  // True for the four opcodes the ALU core implements.
  function automatic logic isValidOp(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_crc4_step.sv
// Combinational CRC4 (x^4+x+1) update over N message bits, MSB first.
// Starting from 0 and feeding the whole message gives the zero-augmented
// remainder, so the byte-wise and nibble-wise steps chain naturally.
// Ports:
//   i_crc  [3:0]   running CRC before this chunk
//   i_data [N-1:0] message bits, bit N-1 is processed first
//   o_crc  [3:0]   running CRC after this chunk
module mtm_alu_crc4_step
  import mtm_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   i_crc,
  input  logic [N-1:0] i_data,
  output logic [3:0]   o_crc
);

  // Bit-serial LFSR unrolled over the chunk: the feedback bit is the
  // outgoing MSB xor the incoming message bit.
  always_comb begin
    logic [3:0] vCrc;
    logic       vFb;
    vCrc = i_crc;
    vFb  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      vFb  = vCrc[3] ^ i_data[i];
      vCrc = {vCrc[2:0], 1'b0} ^ (vFb ? CRC4_POLY : 4'h0);
    end
    o_crc = vCrc;
  end

endmodule

// File: rtl/mtm_alu_frame_decoder.sv
// Assembles one ALU request frame from deserializer packets: 4 B bytes,
// 4 A bytes (MSB byte first), then one CMD byte {0, OP[2:0], CRC[3:0]}.
// On the CMD the frame is checked (packet count, CRC, opcode) and either
// the operands or a single error flag are reported for exactly one cycle.
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_packet [9:0] [9] type (0 DATA, 1 CMD), [8:1] payload, [0] ignored
//   i_data_valid   packet qualifier, one cycle per packet
//   o_a_out  [31:0] operand A, held until the next good frame
//   o_b_out  [31:0] operand B, held until the next good frame
//   o_op_out [2:0]  opcode, held until the next good frame
//   o_frame_valid   one-cycle pulse, operands valid
//   o_err_flags [2:0] {ERR_DATA, ERR_CRC, ERR_OP}, one-hot with o_err_valid
//   o_err_valid     one-cycle pulse, frame rejected
module mtm_alu_frame_decoder
  import mtm_alu_pkg::*;
#(
  parameter int         DATA_PKTS = 8,
  parameter logic [3:0] CRC_INIT  = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_packet,
  input  logic        i_data_valid,
  output logic [31:0] o_a_out,
  output logic [31:0] o_b_out,
  output logic [2:0]  o_op_out,
  output logic        o_frame_valid,
  output logic [2:0]  o_err_flags,
  output logic        o_err_valid
);

  localparam int             CNT_W    = $clog2(DATA_PKTS + 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_PKTS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_PKTS + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_pktCnt;
  logic [3:0]         r_crc;
  logic               r_ovf;
  logic [63:0]        r_shift;

  state_e             w_stateNext;
  logic [CNT_W-1:0]   w_baseCnt;
  logic [CNT_W-1:0]   w_pktCntNext;
  logic [3:0]         w_baseCrc;
  logic [3:0]         w_crcNext;
  logic               w_baseOvf;
  logic               w_ovfNext;
  logic [63:0]        w_shiftNext;
  logic [31:0]        w_aNext;
  logic [31:0]        w_bNext;
  logic [2:0]         w_opNext;
  logic               w_frameValidNext;
  logic               w_errValidNext;
  logic [2:0]         w_errFlagsNext;
  logic               w_errData;
  logic               w_errCrc;
  logic               w_errOp;

  logic               w_pktType;
  logic [7:0]         w_payload;
  logic [2:0]         w_cmdOp;
  logic [3:0]         w_cmdCrc;
  logic [3:0]         w_crcByte;
  logic [3:0]         w_crcCmd;
  logic [1:0]         w_unusedBits;

  assign w_pktType    = i_packet[9];
  assign w_payload    = i_packet[8:1];
  assign w_cmdOp      = w_payload[6:4];
  assign w_cmdCrc     = w_payload[3:0];
  assign w_unusedBits = {i_packet[0], w_payload[7]};

  // Per-frame state seen by the incoming packet. In REPORT the previous
  // frame is already finished, so a packet arriving there starts from a
  // cleared frame; this lets the clear and the first load share one edge.
  always_comb begin
    w_baseCnt = r_pktCnt;
    w_baseCrc = r_crc;
    w_baseOvf = r_ovf;
    if (r_state == ST_REPORT) begin
      w_baseCnt = '0;
      w_baseCrc = CRC_INIT;
      w_baseOvf = 1'b0;
    end
  end

  // Running CRC with the current DATA byte folded in.
  mtm_alu_crc4_step #(.N(8)) u_crcByte (
    .i_crc  (w_baseCrc),
    .i_data (w_payload),
    .o_crc  (w_crcByte)
  );

  // Final CRC for a CMD: the frame trailer nibble {1, OP} folded in.
  mtm_alu_crc4_step #(.N(4)) u_crcCmd (
    .i_crc  (w_baseCrc),
    .i_data ({1'b1, w_cmdOp}),
    .o_crc  (w_crcCmd)
  );

  // Frame checks for a CMD packet, evaluated against the state the CMD
  // sees. The overflow flag keeps a frame doomed even if the saturated
  // count were ever to look like a full frame.
  always_comb begin
    w_errData = (w_baseCnt != CNT_DONE) || w_baseOvf;
    w_errCrc  = (w_crcCmd != w_cmdCrc);
    w_errOp   = !isValidOp(w_cmdOp);
  end

  // Next-state and next-output logic. Pulses default low so they last a
  // single cycle; operands default to holding their last good value.
  always_comb begin
    w_stateNext      = ST_COLLECT;
    w_pktCntNext     = w_baseCnt;
    w_crcNext        = w_baseCrc;
    w_ovfNext        = w_baseOvf;
    w_shiftNext      = r_shift;
    w_aNext          = o_a_out;
    w_bNext          = o_b_out;
    w_opNext         = o_op_out;
    w_frameValidNext = 1'b0;
    w_errValidNext   = 1'b0;
    w_errFlagsNext   = 3'b000;

    if (i_data_valid) begin
      if (w_pktType == PKT_DATA) begin
        w_shiftNext  = {r_shift[55:0], w_payload};
        w_crcNext    = w_crcByte;
        w_pktCntNext = (w_baseCnt == CNT_MAX) ? CNT_MAX : w_baseCnt + CNT_W'(1);
        w_ovfNext    = w_baseOvf || (w_pktCntNext == CNT_MAX);
      end else begin
        w_stateNext = ST_REPORT;
        if (w_errData) begin
          w_errValidNext               = 1'b1;
          w_errFlagsNext[ERR_DATA_BIT] = 1'b1;
        end else if (w_errCrc) begin
          w_errValidNext              = 1'b1;
          w_errFlagsNext[ERR_CRC_BIT] = 1'b1;
        end else if (w_errOp) begin
          w_errValidNext             = 1'b1;
          w_errFlagsNext[ERR_OP_BIT] = 1'b1;
        end else begin
          w_frameValidNext = 1'b1;
          w_bNext          = r_shift[63:32];
          w_aNext          = r_shift[31:0];
          w_opNext         = w_cmdOp;
        end
      end
    end
  end

  // State register. Without a packet COLLECT holds and REPORT returns to
  // COLLECT after its single cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_COLLECT;
    end else if (i_data_valid) begin
      r_state <= w_stateNext;
    end else begin
      r_state <= ST_COLLECT;
    end
  end

  // Frame datapath and registered outputs. Reset discards any partial
  // frame and suppresses every pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pktCnt      <= '0;
      r_crc         <= CRC_INIT;
      r_ovf         <= 1'b0;
      r_shift       <= '0;
      o_a_out       <= '0;
      o_b_out       <= '0;
      o_op_out      <= '0;
      o_frame_valid <= 1'b0;
      o_err_valid   <= 1'b0;
      o_err_flags   <= '0;
    end else begin
      r_pktCnt      <= w_pktCntNext;
      r_crc         <= w_crcNext;
      r_ovf         <= w_ovfNext;
      r_shift       <= w_shiftNext;
      o_a_out       <= w_aNext;
      o_b_out       <= w_bNext;
      o_op_out      <= w_opNext;
      o_frame_valid <= w_frameValidNext;
      o_err_valid   <= w_errValidNext;
      o_err_flags   <= w_errFlagsNext;
    end
  end

endmodule

// File: tb/tb_mtm_alu_frame_decoder.sv
// Self-checking bench for mtm_alu_frame_decoder. Frames are described as
// byte lists; the reference model decides each frame's outcome from the
// byte count, a polynomial long-division CRC and the legal opcode list.
module tb_mtm_alu_frame_decoder;

  logic        clk = 1'b0;
  logic        rstN;
  logic [9:0]  packet;
  logic        dataValid;
  logic [31:0] aOut;
  logic [31:0] bOut;
  logic [2:0]  opOut;
  logic        frameValid;
  logic [2:0]  errFlags;
  logic        errValid;

  int checks   = 0;
  int failures = 0;
  int fvCount  = 0;
  int evCount  = 0;

  logic [7:0]  frameBytes[$];
  logic [31:0] mA;
  logic [31:0] mB;
  logic [2:0]  mOp;
  logic        eFv;
  logic        eEv;
  logic [2:0]  eFlags;
  logic        oFv;
  logic        oEv;
  logic [2:0]  oFlags;
  logic [31:0] oA;
  logic [31:0] oB;
  logic [2:0]  oOp;

  always #5 clk = ~clk;

  mtm_alu_frame_decoder dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_packet      (packet),
    .i_data_valid  (dataValid),
    .o_a_out       (aOut),
    .o_b_out       (bOut),
    .o_op_out      (opOut),
    .o_frame_valid (frameValid),
    .o_err_flags   (errFlags),
    .o_err_valid   (errValid)
  );

  // Counts every pulse seen, so stray or missing pulses show up as totals.
  always @(negedge clk) begin
    if (frameValid) fvCount++;
    if (errValid) evCount++;
  end

  // Zero-augmented remainder of {B, A, 1, OP} over x^4+x+1 by long division.
  function automatic logic [3:0] refCrc(input logic [31:0] b, input logic [31:0] a,
                                        input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  // Outcome of the frame in frameBytes closed by cmd; updates held operands.
  task automatic modelFrame(input logic [7:0] cmd);
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    eFv    = 1'b0;
    eEv    = 1'b1;
    eFlags = 3'b000;
    op     = cmd[6:4];
    if (frameBytes.size() != 8) begin
      eFlags = 3'b100;
    end else begin
      b = {frameBytes[0], frameBytes[1], frameBytes[2], frameBytes[3]};
      a = {frameBytes[4], frameBytes[5], frameBytes[6], frameBytes[7]};
      if (refCrc(b, a, op) != cmd[3:0]) eFlags = 3'b010;
      else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) eFlags = 3'b001;
      else begin
        eFv = 1'b1;
        eEv = 1'b0;
        mA  = a;
        mB  = b;
        mOp = op;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one packet at a falling edge after gap idle cycles; returns at
  // the falling edge after the DUT has sampled it.
  task automatic applyStimulus(input logic isCmd, input logic [7:0] payload, input int gap);
    repeat (gap) @(negedge clk);
    packet    = {isCmd, payload, 1'($urandom)};
    dataValid = 1'b1;
    @(negedge clk);
    dataValid = 1'b0;
    packet    = 10'($urandom);
  endtask

  task automatic loadOperands(input logic [31:0] b, input logic [31:0] a);
    frameBytes.delete();
    for (int i = 3; i >= 0; i--) frameBytes.push_back(b[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frameBytes.push_back(a[i*8 +: 8]);
  endtask

  // Sends frameBytes then the CMD, captures outputs in the REPORT cycle
  // and runs the model for the same frame.
  task automatic sendFrame(input logic [7:0] cmd, input int maxGap);
    int gap;
    foreach (frameBytes[i]) begin
      gap = (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0));
      applyStimulus(1'b0, frameBytes[i], gap);
    end
    gap = (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0));
    applyStimulus(1'b1, cmd, gap);
    oFv    = frameValid;
    oEv    = errValid;
    oFlags = errFlags;
    oA     = aOut;
    oB     = bOut;
    oOp    = opOut;
    modelFrame(cmd);
  endtask

  task automatic test_reset();
    rstN      = 1'b0;
    dataValid = 1'b0;
    packet    = '0;
    mA = '0; mB = '0; mOp = '0;
    idle(3);
    checks++; if (aOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_a got %h want 0", aOut); end
    checks++; if (bOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_b got %h want 0", bOut); end
    checks++; if (opOut !== 3'b000) begin failures++; $display("[TB] FAIL reset_op got %b want 000", opOut); end
    checks++; if (frameValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fv got %b want 0", frameValid); end
    checks++; if (errValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ev got %b want 0", errValid); end
    checks++; if (errFlags !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got %b want 000", errFlags); end
    rstN = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    loadOperands(32'h0, 32'h0);
    sendFrame(8'h0B, 0);
    checks++; if (oFv !== eFv) begin failures++; $display("[TB] FAIL good_fv got %b want %b", oFv, eFv); end
    checks++; if (oEv !== eEv) begin failures++; $display("[TB] FAIL good_ev got %b want %b", oEv, eEv); end
    checks++; if (oA !== mA) begin failures++; $display("[TB] FAIL good_a got %h want %h", oA, mA); end
    checks++; if (oB !== mB) begin failures++; $display("[TB] FAIL good_b got %h want %h", oB, mB); end
    checks++; if (oOp !== mOp) begin failures++; $display("[TB] FAIL good_op got %b want %b", oOp, mOp); end
    idle(1);
    checks++; if (frameValid !== 1'b0) begin failures++; $display("[TB] FAIL good_pulse_width got %b want 0", frameValid); end
    checks++; if (aOut !== mA) begin failures++; $display("[TB] FAIL good_hold_a got %h want %h", aOut, mA); end
    idle(2);
  endtask

  task automatic test_crc_error();
    loadOperands(32'h0, 32'h0);
    sendFrame(8'h0A, 1);
    checks++; if (oEv !== 1'b1 || oEv !== eEv) begin failures++; $display("[TB] FAIL crc_ev got %b want %b", oEv, eEv); end
    checks++; if (oFlags !== eFlags) begin failures++; $display("[TB] FAIL crc_flags got %b want %b", oFlags, eFlags); end
    checks++; if (oFv !== 1'b0) begin failures++; $display("[TB] FAIL crc_fv got %b want 0", oFv); end
    idle(2);
  endtask

  task automatic test_bad_opcode();
    logic [31:0] b;
    logic [31:0] a;
    loadOperands(32'h0, 32'h0);
    sendFrame(8'h2D, 1);
    checks++; if (oFlags !== eFlags || !oEv) begin failures++; $display("[TB] FAIL badop_flags got %b/%b want %b/1", oFlags, oEv, eFlags); end
    checks++; if (oFv !== 1'b0) begin failures++; $display("[TB] FAIL badop_fv got %b want 0", oFv); end
    // A good frame first, so a rejected one must leave these operands.
    b = $urandom; a = $urandom;
    loadOperands(b, a);
    sendFrame({1'b0, 3'b101, refCrc(b, a, 3'b101)}, 0);
    loadOperands($urandom, $urandom);
    sendFrame(8'h7F, 0);
    checks++; if (oA !== mA || oB !== mB || oOp !== mOp) begin failures++; $display("[TB] FAIL err_hold got %h %h %b want %h %h %b", oA, oB, oOp, mA, mB, mOp); end
    idle(2);
  endtask

  task automatic test_count_error();
    loadOperands(32'h0, 32'h0);
    void'(frameBytes.pop_back());
    sendFrame(8'h0B, 0);
    checks++; if (oFlags !== eFlags || !oEv) begin failures++; $display("[TB] FAIL cnt7_flags got %b/%b want %b/1", oFlags, oEv, eFlags); end
    idle(2);
    loadOperands(32'h0, 32'h0);
    frameBytes.push_back(8'h00);
    frameBytes.push_back(8'h00);
    sendFrame(8'h0A, 1);
    checks++; if (oFlags !== eFlags || !oEv) begin failures++; $display("[TB] FAIL cnt10_flags got %b/%b want %b/1", oFlags, oEv, eFlags); end
    idle(2);
    frameBytes.delete();
    sendFrame(8'h0B, 0);
    checks++; if (oFlags !== eFlags || !oEv) begin failures++; $display("[TB] FAIL cnt0_flags got %b/%b want %b/1", oFlags, oEv, eFlags); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    logic [31:0] a;
    b = $urandom; a = $urandom;
    loadOperands(b, a);
    sendFrame({1'b0, 3'b001, refCrc(b, a, 3'b001)}, 0);
    checks++; if (oFv !== eFv || oA !== mA || oB !== mB) begin failures++; $display("[TB] FAIL b2b_first got %b %h %h want %b %h %h", oFv, oA, oB, eFv, mA, mB); end
    loadOperands(32'h01020304, 32'h05060708);
    sendFrame({1'b0, 3'b100, refCrc(32'h01020304, 32'h05060708, 3'b100)}, 0);
    checks++; if (oFv !== 1'b1 || oEv !== 1'b0) begin failures++; $display("[TB] FAIL b2b_fv got %b/%b want 1/0", oFv, oEv); end
    checks++; if (oA !== 32'h05060708) begin failures++; $display("[TB] FAIL b2b_a got %h want 05060708", oA); end
    checks++; if (oB !== 32'h01020304) begin failures++; $display("[TB] FAIL b2b_b got %h want 01020304", oB); end
    checks++; if (oOp !== 3'b100) begin failures++; $display("[TB] FAIL b2b_op got %b want 100", oOp); end
    idle(2);
  endtask

  task automatic test_random();
    int          n;
    int          pulsesBefore;
    logic [2:0]  op;
    logic [3:0]  crc;
    logic [31:0] b;
    logic [31:0] a;
    pulsesBefore = fvCount + evCount;
    for (int f = 0; f < 40; f++) begin
      b  = $urandom; a = $urandom;
      op = 3'($urandom);
      loadOperands(b, a);
      n = ($urandom_range(7, 0) < 6) ? 8 : int'($urandom_range(11, 0));
      while (frameBytes.size() > n) void'(frameBytes.pop_back());
      while (frameBytes.size() < n) frameBytes.push_back(8'($urandom));
      crc = refCrc(b, a, op);
      if ($urandom_range(3, 0) == 0) crc = crc ^ 4'($urandom_range(15, 1));
      sendFrame({1'b0, op, crc}, ($urandom_range(1, 0) == 0) ? 0 : 2);
      checks++; if (oFv !== eFv || oEv !== eEv) begin failures++; $display("[TB] FAIL rnd%0d_pulse got %b/%b want %b/%b", f, oFv, oEv, eFv, eEv); end
      if (eEv) begin
        checks++; if (oFlags !== eFlags) begin failures++; $display("[TB] FAIL rnd%0d_flags got %b want %b", f, oFlags, eFlags); end
      end
      checks++; if (oA !== mA || oB !== mB || oOp !== mOp) begin failures++; $display("[TB] FAIL rnd%0d_ops got %h %h %b want %h %h %b", f, oA, oB, oOp, mA, mB, mOp); end
    end
    idle(2);
    checks++;
    if (fvCount + evCount - pulsesBefore !== 40) begin
      failures++; $display("[TB] FAIL rnd_pulse_total got %0d want 40", fvCount + evCount - pulsesBefore);
    end
  endtask

  task automatic test_reset_mid_frame();
    int          fvBefore;
    int          evBefore;
    logic [31:0] b;
    logic [31:0] a;
    fvBefore = fvCount;
    evBefore = evCount;
    loadOperands($urandom, $urandom);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, frameBytes[i], 0);
    rstN = 1'b0;
    mA = '0; mB = '0; mOp = '0;
    idle(2);
    checks++; if (aOut !== 32'h0 || bOut !== 32'h0 || opOut !== 3'b000) begin failures++; $display("[TB] FAIL midrst_ops got %h %h %b want 0 0 0", aOut, bOut, opOut); end
    rstN = 1'b1;
    idle(2);
    b = $urandom; a = $urandom;
    loadOperands(b, a);
    sendFrame({1'b0, 3'b000, refCrc(b, a, 3'b000)}, 1);
    checks++; if (oFv !== 1'b1 || oA !== mA || oB !== mB) begin failures++; $display("[TB] FAIL midrst_frame got %b %h %h want 1 %h %h", oFv, oA, oB, mA, mB); end
    idle(3);
    checks++; if (fvCount - fvBefore !== 1) begin failures++; $display("[TB] FAIL midrst_fv_count got %0d want 1", fvCount - fvBefore); end
    checks++; if (evCount - evBefore !== 0) begin failures++; $display("[TB] FAIL midrst_ev_count got %0d want 0", evCount - evBefore); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_bad_opcode();
    test_count_error();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
